// File: rtl/butterfly_stage_scheduler.sv
// butterfly_stage_scheduler
//   Sequences one butterfly_processor job. A command carries a transform length
//   and an FFT/IFFT select. Legal lengths start a job that streams
//   log2(length) * (length / (2*BU_PAR)) weight beats, stage-major, from a
//   weight RAM into the processor. The job then waits for `length` input beats
//   and `length` output beats, and pulses `done`. Illegal lengths pulse `err_len`
//   and leave the block idle.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_vld/cmd_rdy       command handshake; cmd_length, cmd_is_fft are payload
//   wmem_rd_en/_addr/_dat weight RAM read port (data valid 1 cycle after rd_en)
//   bp_length, bp_is_fft  job parameters to the processor, latched at accept
//   bp_weight_vld/_dat    weight beat stream to the processor
//   in_beat, out_beat     processor input / serial-output handshake strobes
//   abort                 (only with BFLY_SCHED_ABORT_EN) cancel the running job
//   busy, done, err_len   status: not-idle, job-complete pulse, bad-length pulse
//
// Handshake: a command transfers on a cycle where cmd_vld && cmd_rdy are both
// high. cmd_rdy is high only in IDLE and does not depend on cmd_vld. The
// sender holds the payload stable until the transfer happens.
//
// Build option: define BFLY_SCHED_ABORT_EN to add the abort input.
module butterfly_stage_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int BU_PAR     = 4,
    parameter int MAX_LENGTH = 1024,
    parameter int ADDR_W     = 11
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_vld,
    output logic                           cmd_rdy,
    input  logic [15:0]                    cmd_length,
    input  logic                           cmd_is_fft,
    output logic                           wmem_rd_en,
    output logic [ADDR_W-1:0]              wmem_rd_addr,
    input  logic [DATA_WIDTH*4*BU_PAR-1:0] wmem_rd_dat,
    output logic [15:0]                    bp_length,
    output logic                           bp_is_fft,
    output logic                           bp_weight_vld,
    output logic [DATA_WIDTH*4*BU_PAR-1:0] bp_weight_dat,
    input  logic                           in_beat,
    input  logic                           out_beat,
`ifdef BFLY_SCHED_ABORT_EN
    input  logic                           abort,
`endif
    output logic                           busy,
    output logic                           done,
    output logic                           err_len
);

    // Depth = length / (2*BU_PAR), so the divide is a shift.
    localparam int          DEPTH_SHIFT = $clog2(2 * BU_PAR);
    localparam logic [15:0] MIN_LEN     = 16'(2 * BU_PAR);
    localparam logic [15:0] MAX_LEN     = 16'(MAX_LENGTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_WAIT_IN = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q;
    logic                fft_q;
    logic [15:0]         total_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         in_cnt_q;
    logic [15:0]         out_cnt_q;
    logic                err_q;
    logic                vld_q;

    logic                abort_w;
    logic                accept;
    logic                len_legal;
    logic [4:0]          stages_w;
    logic [15:0]         depth_w;
    logic [15:0]         total_w;
    logic                last_addr;
    logic                in_done;
    logic                out_done;
    logic                in_count_en;
    logic                out_count_en;

`ifdef BFLY_SCHED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Length decode: power of two within [2*BU_PAR, MAX_LENGTH]; stages is the
    // index of the single set bit.
    always_comb begin
        stages_w = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (cmd_length[i]) stages_w = 5'(i);
        end
        depth_w   = cmd_length >> DEPTH_SHIFT;
        total_w   = depth_w * {11'd0, stages_w};
        len_legal = ((cmd_length & (cmd_length - 16'd1)) == 16'd0) &&
                    (cmd_length >= MIN_LEN) && (cmd_length <= MAX_LEN);
    end

    assign accept    = cmd_vld && cmd_rdy;
    assign last_addr = ({{(16-ADDR_W){1'b0}}, addr_q} == (total_q - 16'd1));

    // "Done" includes the beat arriving this cycle so the simultaneous case
    // (last weight address together with the final input beat) goes straight
    // to RUN.
    assign in_done  = (in_cnt_q == len_q) || (in_beat && (in_cnt_q == len_q - 16'd1));
    assign out_done = (out_cnt_q == len_q) || (out_beat && (out_cnt_q == len_q - 16'd1));

    // Counting stops at len_q so surplus beats never leak into a later job.
    assign in_count_en  = in_beat && (in_cnt_q != len_q) &&
                          ((state_q == S_LOAD_W) || (state_q == S_WAIT_IN));
    assign out_count_en = out_beat && (out_cnt_q != len_q) &&
                          ((state_q == S_WAIT_IN) || (state_q == S_RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cmd_rdy    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        wmem_rd_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_rdy = 1'b1;
                busy    = 1'b0;
                if (accept && len_legal) state_d = S_LOAD_W;
            end
            S_LOAD_W: begin
                wmem_rd_en = 1'b1;
                if (last_addr) state_d = in_done ? S_RUN : S_WAIT_IN;
            end
            S_WAIT_IN: begin
                if (in_done) state_d = S_RUN;
            end
            S_RUN: begin
                if (out_done) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_w && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            fft_q     <= 1'b0;
            total_q   <= '0;
            addr_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            err_q <= accept && !len_legal;
            // Abort must silence the weight stream on the very next cycle.
            vld_q <= wmem_rd_en && !abort_w;
            if (accept && len_legal) begin
                len_q   <= cmd_length;
                fft_q   <= cmd_is_fft;
                total_q <= total_w;
            end
            if (state_d == S_IDLE) begin
                addr_q    <= '0;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if ((state_q == S_LOAD_W) && !last_addr) addr_q <= addr_q + 1'b1;
                if (in_count_en)  in_cnt_q  <= in_cnt_q + 16'd1;
                if (out_count_en) out_cnt_q <= out_cnt_q + 16'd1;
            end
        end
    end

    assign wmem_rd_addr  = addr_q;
    assign bp_length     = len_q;
    assign bp_is_fft     = fft_q;
    assign err_len       = err_q;
    assign bp_weight_vld = vld_q;
    // RAM data already arrives one cycle after the read; gate it so the beat
    // bus reads zero whenever no beat is valid.
    assign bp_weight_dat = vld_q ? wmem_rd_dat : '0;

endmodule

// File: tb/tb_butterfly_stage_scheduler.sv
module tb_butterfly_stage_scheduler;
  localparam int WW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_vld = 1'b0;
  logic          cmd_rdy;
  logic [15:0]   cmd_length = '0;
  logic          cmd_is_fft = 1'b0;
  logic          wmem_rd_en;
  logic [10:0]   wmem_rd_addr;
  logic [WW-1:0] wmem_rd_dat;
  logic [15:0]   bp_length;
  logic          bp_is_fft;
  logic          bp_weight_vld;
  logic [WW-1:0] bp_weight_dat;
  logic          in_beat = 1'b0;
  logic          out_beat = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic          err_len;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int vld_cnt = 0;

  // {cmd_rdy, busy, done, err_len, wmem_rd_en, bp_weight_vld}
  logic [5:0] st;
  assign st = {cmd_rdy, busy, done, err_len, wmem_rd_en, bp_weight_vld};

  butterfly_stage_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_vld       (cmd_vld),
    .cmd_rdy       (cmd_rdy),
    .cmd_length    (cmd_length),
    .cmd_is_fft    (cmd_is_fft),
    .wmem_rd_en    (wmem_rd_en),
    .wmem_rd_addr  (wmem_rd_addr),
    .wmem_rd_dat   (wmem_rd_dat),
    .bp_length     (bp_length),
    .bp_is_fft     (bp_is_fft),
    .bp_weight_vld (bp_weight_vld),
    .bp_weight_dat (bp_weight_dat),
    .in_beat       (in_beat),
    .out_beat      (out_beat),
`ifdef BFLY_SCHED_ABORT_EN
    .abort         (abort),
`endif
    .busy          (busy),
    .done          (done),
    .err_len       (err_len)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // weight RAM model: synchronous read, word content derived from address
  function automatic logic [WW-1:0] word(input logic [10:0] a);
    logic [31:0] p;
    p = {5'd0, a, 5'd31, ~a} ^ 32'h3C5A_0000;
    return {8{p}};
  endfunction

  logic [WW-1:0] ram_q = '0;
  always @(posedge clk) if (wmem_rd_en) ram_q <= word(wmem_rd_addr);
  assign wmem_rd_dat = ram_q;

  // event monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bp_weight_vld) vld_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] len, input logic fft);
    int t;
    cmd_length = len;
    cmd_is_fft = fft;
    cmd_vld = 1'b1;
    t = 0;
    while (!cmd_rdy && t < 2000) begin
      tick();
      t++;
    end
    if (!cmd_rdy) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout len=%0d cmd_rdy got 0 exp 1", len);
    end
    tick();
    cmd_vld = 1'b0;
  endtask

  // n beats on in_beat (sel_out=0) or out_beat (sel_out=1); optional idle gaps
  task automatic drive_beats(input int n, input bit sel_out, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (sel_out) out_beat = 1'b1;
      else in_beat = 1'b1;
      tick();
      in_beat = 1'b0;
      out_beat = 1'b0;
      if (gaps && (i % 3 == 1) && (i != n - 1)) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (st !== 6'b100000) begin errors++; $display("FAIL reset_status got %b exp 100000", st); end
    checks++;
    if ({bp_length, bp_is_fft, wmem_rd_addr} !== 28'd0) begin
      errors++;
      $display("FAIL reset_regs got len=%0d fft=%b addr=%0d exp 0", bp_length, bp_is_fft, wmem_rd_addr);
    end
    checks++;
    if (bp_weight_dat !== '0) begin errors++; $display("FAIL reset_wdat got %h exp 0", bp_weight_dat); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (st !== 6'b100000) begin errors++; $display("FAIL post_reset_status got %b exp 100000", st); end
  endtask

  task automatic test_illegal_length();
    logic [15:0] lens [3];
    int d0, v0;
    lens[0] = 16'd96;
    lens[1] = 16'd4;
    lens[2] = 16'd2048;
    d0 = done_cnt;
    v0 = vld_cnt;
    for (int i = 0; i < 3; i++) begin
      send_cmd(lens[i], 1'b1);
      checks++;
      if (st !== 6'b100100) begin errors++; $display("FAIL err_len_pulse len=%0d got %b exp 100100", lens[i], st); end
      checks++;
      if (bp_length !== 16'd0) begin errors++; $display("FAIL err_bp_length got %0d exp 0", bp_length); end
      tick();
      checks++;
      if (st !== 6'b100000) begin errors++; $display("FAIL err_len_clear len=%0d got %b exp 100000", lens[i], st); end
    end
    checks++;
    if ((done_cnt - d0) !== 0 || (vld_cnt - v0) !== 0) begin
      errors++;
      $display("FAIL err_no_activity got done=%0d vld=%0d exp 0 0", done_cnt - d0, vld_cnt - v0);
    end
  endtask

  task automatic test_len128();
    int d0, v0;
    d0 = done_cnt;
    v0 = vld_cnt;
    send_cmd(16'd128, 1'b1);
    checks++;
    if (bp_length !== 16'd128 || bp_is_fft !== 1'b1) begin
      errors++;
      $display("FAIL l128_params got len=%0d fft=%b exp 128 1", bp_length, bp_is_fft);
    end
    for (int k = 0; k < 112; k++) begin
      checks++;
      if (st !== ((k == 0) ? 6'b010010 : 6'b010011)) begin errors++; $display("FAIL l128_stream_status k=%0d got %b", k, st); end
      checks++;
      if (wmem_rd_addr !== 11'(k)) begin errors++; $display("FAIL l128_addr got %0d exp %0d", wmem_rd_addr, k); end
      if (k > 0) begin
        checks++;
        if (bp_weight_dat !== word(11'(k - 1))) begin errors++; $display("FAIL l128_wdat beat=%0d got %h", k - 1, bp_weight_dat[31:0]); end
      end
      tick();
    end
    checks++;
    if (st !== 6'b010001) begin errors++; $display("FAIL l128_last_beat got %b exp 010001", st); end
    checks++;
    if (bp_weight_dat !== word(11'd111)) begin errors++; $display("FAIL l128_last_wdat got %h", bp_weight_dat[31:0]); end
    tick();
    checks++;
    if (st !== 6'b010000) begin errors++; $display("FAIL l128_stream_end got %b exp 010000", st); end
    checks++;
    if ((vld_cnt - v0) !== 112) begin errors++; $display("FAIL l128_beat_count got %0d exp 112", vld_cnt - v0); end
    drive_beats(128, 1'b0, 1'b1);
    tick();
    checks++;
    if (st !== 6'b010000) begin errors++; $display("FAIL l128_run_busy got %b exp 010000", st); end
    drive_beats(128, 1'b1, 1'b1);
    checks++;
    if (st !== 6'b011000) begin errors++; $display("FAIL l128_done got %b exp 011000", st); end
    tick();
    checks++;
    if (st !== 6'b100000) begin errors++; $display("FAIL l128_idle got %b exp 100000", st); end
    checks++;
    if ((done_cnt - d0) !== 1) begin errors++; $display("FAIL l128_done_count got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_small_and_busy_cmd();
    int d0, v0;
    d0 = done_cnt;
    v0 = vld_cnt;
    send_cmd(16'd8, 1'b0);
    // a second command offered while busy must not be taken
    cmd_vld = 1'b1;
    cmd_length = 16'd16;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (st !== ((k == 0) ? 6'b010010 : 6'b010011)) begin errors++; $display("FAIL l8_status k=%0d got %b", k, st); end
      checks++;
      if (wmem_rd_addr !== 11'(k)) begin errors++; $display("FAIL l8_addr got %0d exp %0d", wmem_rd_addr, k); end
      tick();
    end
    checks++;
    if (st !== 6'b010001 || bp_weight_dat !== word(11'd2)) begin
      errors++;
      $display("FAIL l8_last_beat got %b %h exp 010001 word2", st, bp_weight_dat[31:0]);
    end
    checks++;
    if (bp_length !== 16'd8 || bp_is_fft !== 1'b0) begin
      errors++;
      $display("FAIL busy_cmd_ignored got len=%0d fft=%b exp 8 0", bp_length, bp_is_fft);
    end
    cmd_vld = 1'b0;
    tick();
    drive_beats(8, 1'b0, 1'b0);
    drive_beats(8, 1'b1, 1'b0);
    checks++;
    if (st !== 6'b011000) begin errors++; $display("FAIL l8_done got %b exp 011000", st); end
    tick();
    checks++;
    if (st !== 6'b100000 || bp_length !== 16'd8) begin errors++; $display("FAIL l8_idle got %b len=%0d", st, bp_length); end
    checks++;
    if ((done_cnt - d0) !== 1 || (vld_cnt - v0) !== 3) begin
      errors++;
      $display("FAIL l8_counts got done=%0d beats=%0d exp 1 3", done_cnt - d0, vld_cnt - v0);
    end
  endtask

  // length 256: 8 stages * 32 = 256 weight beats, the same as the input count
  task automatic test_back_to_back_simultaneous();
    int d0;
    d0 = done_cnt;
    send_cmd(16'd256, 1'b1);
    in_beat = 1'b1;
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (wmem_rd_en !== 1'b1 || wmem_rd_addr !== 11'(k)) begin
        errors++;
        $display("FAIL sim_addr got en=%b addr=%0d exp 1 %0d", wmem_rd_en, wmem_rd_addr, k);
      end
      tick();
    end
    in_beat = 1'b0;
    checks++;
    if (st !== 6'b010001 || bp_weight_dat !== word(11'd255)) begin
      errors++;
      $display("FAIL sim_last_beat got %b %h exp 010001 word255", st, bp_weight_dat[31:0]);
    end
    drive_beats(256, 1'b1, 1'b0);
    checks++;
    if (st !== 6'b011000) begin errors++; $display("FAIL sim_done got %b exp 011000", st); end
    tick();
    checks++;
    if ((done_cnt - d0) !== 1 || st !== 6'b100000) begin
      errors++;
      $display("FAIL sim_finish got done=%0d st=%b exp 1 100000", done_cnt - d0, st);
    end
  endtask

  task automatic test_reset_midjob();
    int d0, v0;
    d0 = done_cnt;
    send_cmd(16'd128, 1'b0);
    repeat (50) tick();
    checks++;
    if (wmem_rd_addr !== 11'd50 || st !== 6'b010011) begin
      errors++;
      $display("FAIL mid_pre_reset got addr=%0d st=%b exp 50 010011", wmem_rd_addr, st);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (st !== 6'b100000 || bp_length !== 16'd0 || wmem_rd_addr !== 11'd0 || bp_weight_dat !== '0) begin
      errors++;
      $display("FAIL mid_reset_values got st=%b len=%0d addr=%0d", st, bp_length, wmem_rd_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL mid_reset_no_done got %0d exp %0d", done_cnt, d0); end
    v0 = vld_cnt;
    send_cmd(16'd16, 1'b1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wmem_rd_en !== 1'b1 || wmem_rd_addr !== 11'(k)) begin
        errors++;
        $display("FAIL restart_addr got en=%b addr=%0d exp 1 %0d", wmem_rd_en, wmem_rd_addr, k);
      end
      tick();
    end
    tick();
    drive_beats(16, 1'b0, 1'b1);
    drive_beats(16, 1'b1, 1'b1);
    tick();
    checks++;
    if ((done_cnt - d0) !== 1 || (vld_cnt - v0) !== 8 || st !== 6'b100000) begin
      errors++;
      $display("FAIL restart_job got done=%0d beats=%0d st=%b exp 1 8 100000", done_cnt - d0, vld_cnt - v0, st);
    end
  endtask

`ifdef BFLY_SCHED_ABORT_EN
  task automatic test_abort();
    int d0, v0;
    d0 = done_cnt;
    send_cmd(16'd128, 1'b1);
    repeat (113) tick();
    drive_beats(128, 1'b0, 1'b0);
    drive_beats(60, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (st !== 6'b100000) begin errors++; $display("FAIL abort_idle got %b exp 100000", st); end
    tick();
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done got %0d exp %0d", done_cnt, d0); end
    v0 = vld_cnt;
    // abort while idle coincides with the next command: accepted normally
    abort = 1'b1;
    send_cmd(16'd64, 1'b0);
    abort = 1'b0;
    for (int k = 0; k < 48; k++) begin
      checks++;
      if (wmem_rd_en !== 1'b1 || wmem_rd_addr !== 11'(k)) begin
        errors++;
        $display("FAIL abort_next_addr got en=%b addr=%0d exp 1 %0d", wmem_rd_en, wmem_rd_addr, k);
      end
      tick();
    end
    tick();
    drive_beats(64, 1'b0, 1'b0);
    drive_beats(64, 1'b1, 1'b0);
    checks++;
    if (st !== 6'b011000) begin errors++; $display("FAIL abort_next_done got %b exp 011000", st); end
    tick();
    checks++;
    if ((done_cnt - d0) !== 1 || (vld_cnt - v0) !== 48) begin
      errors++;
      $display("FAIL abort_next_counts got done=%0d beats=%0d exp 1 48", done_cnt - d0, vld_cnt - v0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_illegal_length();
    test_len128();
    test_small_and_busy_cmd();
    test_back_to_back_simultaneous();
    test_reset_midjob();
`ifdef BFLY_SCHED_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
